// File: rtl/uart_tx_param.sv
// uart_tx_param: memory-mapped UART transmitter with a transmit FIFO and runtime frame format.
// Define UART_TX_IRQ_EN to build the transmit-done interrupt; otherwise irq is tied low.
module uart_tx_param #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        tx_out,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [DIV_W-1:0] CNT_ONE = 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr, level;
    logic [7:0] last_data, shreg, lvl8;
    logic [6:0] ctrl;
    logic [DIV_W-1:0] divisor, f_div, cnt;
    logic [1:0] f_len, sel;
    logic [2:0] bit_idx;
    logic f_par, f_odd, f_two, par, stop_idx, overflow;
    logic empty, full, busy, push, pop, start_ok, bit_end, stop_done, unused_bits;
    assign sel = addr[3:2];
    assign empty = wptr == rptr;
    assign full = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
    assign level = wptr - rptr;
    assign lvl8 = {{(7-AW){1'b0}}, level};
    assign busy = state != IDLE;
    assign push = wr_en && sel == 2'd0;
    assign start_ok = ctrl[0] && divisor != '0 && !empty;
    assign bit_end = cnt == f_div - CNT_ONE;
    assign stop_done = state == STOP && bit_end && (stop_idx || !f_two);
    assign pop = start_ok && (state == IDLE || stop_done);
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:8]};
`ifdef UART_TX_IRQ_EN
    localparam logic [6:0] CTRL_MASK = 7'h7f;
    always_ff @(posedge clk)
        irq <= reset ? 1'b0 : ctrl[6] && empty && state == IDLE;
`else
    localparam logic [6:0] CTRL_MASK = 7'h3f;
    assign irq = 1'b0;
`endif
    // A push while full is accepted only when the head leaves in the same cycle
    always_ff @(posedge clk)
        if (push && (!full || pop)) mem[wptr[AW-1:0]] <= wdata[7:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            last_data <= '0;
            ctrl <= '0;
            divisor <= '0;
            overflow <= 1'b0;
            rdata <= '0;
        end else begin
            if (push) last_data <= wdata[7:0];
            if (push && (!full || pop)) wptr <= wptr + PTR_ONE;
            if (push && full && !pop) overflow <= 1'b1;
            if (wr_en && sel == 2'd2 && wdata[3]) overflow <= 1'b0;
            if (pop) rptr <= rptr + PTR_ONE;
            if (wr_en && sel == 2'd1) ctrl <= wdata[6:0] & CTRL_MASK;
            if (wr_en && sel == 2'd3) divisor <= wdata[DIV_W-1:0];
            if (rd_en) rdata <= sel == 2'd0 ? {24'd0, last_data} :
                                sel == 2'd1 ? {25'd0, ctrl} :
                                sel == 2'd2 ? {16'd0, lvl8, 4'd0, overflow, busy, full, empty} :
                                {{(32-DIV_W){1'b0}}, divisor};
        end
    end
    // tx_out is the registered image of the current state, so the line lags the FSM by one clock
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx_out <= 1'b1;
            cnt <= '0;
            shreg <= '0;
            f_div <= '0;
            f_len <= '0;
            f_par <= 1'b0;
            f_odd <= 1'b0;
            f_two <= 1'b0;
            par <= 1'b0;
            bit_idx <= '0;
            stop_idx <= 1'b0;
        end else begin
            tx_out <= state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? par ^ f_odd : 1'b1;
            cnt <= state == IDLE || bit_end ? '0 : cnt + CNT_ONE;
            if (pop) begin
                shreg <= mem[rptr[AW-1:0]];
                f_div <= divisor;
                f_len <= ctrl[5:4];
                f_par <= ctrl[2];
                f_odd <= ctrl[3];
                f_two <= ctrl[1];
                par <= 1'b0;
            end
            case (state)
                IDLE: if (pop) state <= START;
                START: if (bit_end) begin
                    state <= DATA;
                    bit_idx <= '0;
                end
                DATA: if (bit_end) begin
                    shreg <= shreg >> 1;
                    par <= par ^ shreg[0];
                    bit_idx <= bit_idx + 3'd1;
                    stop_idx <= 1'b0;
                    if (bit_idx == {1'b0, f_len} + 3'd4) state <= f_par ? PARITY : STOP;
                end
                PARITY: if (bit_end) begin
                    state <= STOP;
                    stop_idx <= 1'b0;
                end
                STOP: if (bit_end) begin
                    stop_idx <= 1'b1;
                    if (stop_idx || !f_two) state <= pop ? START : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised, memory-mapped UART transmitter with a configurable-depth transmit FIFO. It supports runtime-selectable character length, parity mode and stop-bit count. The block sits on the pipeline's data-memory bus beside the other UART peripherals. It serialises queued characters onto `tx_out`, LSB first.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: transmit FIFO entries; power of two, 2..64.
- `DIV_W`, default 16: baud divisor width, 4..24.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `addr` in 32: byte address; bits [3:2] select the register, other bits ignored.
- `wdata` in 32: write data.
- `wr_en` in 1: register write strobe.
- `rd_en` in 1: register read strobe.
- `rdata` out 32: registered read data.
- `tx_out` out 1: serial line; idles high.
- `irq` out 1: transmit-done interrupt; see Configuration.

## Operation
Register map:
- 0x0 DATA
  - Write: push `wdata[7:0]` to the FIFO.
  - Read: last byte written.
- 0x4 CTRL, R/W:
  - [0] `tx_en`.
  - [1] `two_stop`.
  - [2] `par_en`.
  - [3] `odd_par`.
  - [5:4] `len`: 0/1/2/3 selects 5/6/7/8 data bits.
  - [6] `irq_en`.
- 0x8 STATUS:
  - [0] empty, read-only.
  - [1] full, read-only.
  - [2] busy, read-only.
  - [3] overflow, sticky; write 1 to clear.
  - [15:8] FIFO level, read-only.
- 0xC BAUD, R/W: `divisor[DIV_W-1:0]`. A value of 0 halts frame starts.

FIFO:
- Circular buffer with `$clog2(FIFO_DEPTH)+1`-bit read/write pointers; full is detected by MSB mismatch.
- Push while full and no pop in the same cycle: data dropped, overflow set.
- Push and pop in the same cycle: both take effect, even when full; level unchanged.

FSM, states IDLE → START → DATA → PARITY → STOP → IDLE:
- **IDLE**: `tx_out=1`. When `tx_en`, divisor≠0 and FIFO not empty:
  - pop the head entry into the shift register;
  - latch `len`, `par_en`, `odd_par`, `two_stop` and divisor into frame registers;
  - go to START.
- **START**: `tx_out=0` for one bit time.
- **DATA**: shift LSB first for `len+5` bit times.
- **PARITY**: entered only if `par_en`.
  - Parity bit = XOR of the transmitted data bits.
  - The bit is inverted when `odd_par`, so that the total number of ones is odd.
- **STOP**: `tx_out=1` for 1 or 2 bit times.
  - At the end, return to IDLE.
  - If the pop conditions hold, go directly to START without an idle bit.
- A bit time is `divisor` clocks. The baud counter resets on every bit boundary; a bit ends when counter == divisor−1.
- CTRL and BAUD writes during a frame affect only the next frame.
- Clearing `tx_en` mid-frame: the current frame completes; queued data stays in the FIFO.
- busy = state≠IDLE.

Reset: FIFO empty, all registers 0, FSM IDLE, `tx_out=1`, `rdata=0`, `irq=0`.

## Timing
- `rdata` updates on the clock edge after `rd_en`, and holds otherwise. Reads have no side effects.
- Writes take effect at the strobe edge.
- Latency, FIFO empty, FSM IDLE: a DATA write at edge N puts the start bit on `tx_out` from edge N+2.
- Frame length is (1 + data bits + parity bit + stop bits) × divisor clocks. Example: 8N1 with divisor 4 is 40 clocks.
- `tx_out` is driven from a flop; it is glitch-free.
- Reset asserted mid-frame: `tx_out=1` from the next edge, the frame is lost and the FIFO is flushed.

## Configuration
- `UART_TX_IRQ_EN` defined:
  - `irq` is registered.
  - `irq` = `irq_en` && FIFO empty && state IDLE.
  - It asserts 1 clock after the last stop bit ends, and deasserts on the edge after a DATA push or an `irq_en` clear.
- Undefined: `irq` is tied 0, CTRL[6] reads 0, and no interrupt logic is built.

## Test plan
- BAUD=4, CTRL=0x31 (8N1), write DATA=0xA5 → `tx_out` = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 clocks; 40 clocks total; busy then clears.
- CTRL=0x3D (8O1), DATA=0x03 → parity bit 1; CTRL=0x35 (8E1), DATA=0x03 → parity bit 0; frame is 44 clocks at BAUD=4.
- CTRL=0x01 (5-bit), DATA=0xFF → five 1 data bits, then stop; next frame starts immediately if the FIFO is not empty.
- `tx_en`=0, write 9 bytes with FIFO_DEPTH=8 → STATUS = full, level 8, overflow 1. Write STATUS bit3=1 → overflow 0. Set `tx_en` → exactly 8 frames back-to-back.
- Assert reset on clock 10 of a frame → `tx_out`=1 on the next edge, STATUS level 0, `rdata`=0.
- With `UART_TX_IRQ_EN` and `irq_en`=1, one byte sent → `irq` rises 1 clock after the stop bit ends, and falls after a DATA write.
